// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath with a shared ALU and a unified memory.
// It stalls on mem_ready and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             LuOp,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EX_R   = 4'd2,
        S_WB_R   = 4'd3,
        S_MEMADR = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_MEM_WR = 4'd7,
        S_EX_I   = 4'd8,
        S_WB_I   = 4'd9,
        S_BEQ    = 4'd10,
        S_J      = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             retire;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IF;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;

        unique case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // The IR/PC loads are masked while reset is held so that nothing is written.
                IRWrite = mem_ready & reset;
                PCWrite = mem_ready & reset;
                if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                unique case (OpCode)
                    6'h00:   state_d = (Funct == 6'h08 || Funct == 6'h09) ? S_JR : S_EX_R;
                    6'h23,
                    6'h2b:   state_d = S_MEMADR;
                    6'h04:   state_d = S_BEQ;
                    6'h02:   state_d = S_J;
                    6'h03:   state_d = S_JAL;
                    6'h08, 6'h09, 6'h0a,
                    6'h0b, 6'h0c, 6'h0f:
                             state_d = S_EX_I;
                    default: state_d = S_IF;
                endcase
            end
            S_EX_R: begin
                ALUSrcA = (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03) ? 2'b10 : 2'b01;
                ALUOp   = 2'b10;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = (OpCode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EX_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_BEQ: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                state_d     = S_IF;
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                if (Funct == 6'h09) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b10;
                end
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + 1'b1;
    end

    assign ExtOp       = (OpCode != 6'h0c);
    assign LuOp        = (OpCode == 6'h0f);
    assign state       = state_q;
    assign instr_done  = retire;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: each instruction is expanded into its expected state walk
// (including stalls) and every cycle's controls, retire pulse and count are compared.
module tb_multicycle_control;

    localparam int ST_IF = 0, ST_ID = 1, ST_EXR = 2, ST_WBR = 3, ST_MA = 4, ST_MRD = 5,
                   ST_MWB = 6, ST_MWR = 7, ST_EXI = 8, ST_WBI = 9, ST_BEQ = 10,
                   ST_J = 11, ST_JAL = 12, ST_JR = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  OpCode, Funct;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
    logic        ExtOp, LuOp, instr_done;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp), .state(state),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int unsigned model_count = 0;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    step_t plan[$];
    bit    plan_legal;

    logic [20:0] obs_ctrl;
    assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegDst,
                       MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word for one state, straight from the per-state output table.
    function automatic logic [20:0] exp_ctrl(input int st, input logic [5:0] op,
                                             input logic [5:0] fn, input bit mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0;
        logic [1:0] rdst = 0, m2r = 0, sa = 0, sb = 0, aop = 0, pcs = 0;
        case (st)
            ST_IF:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            ST_ID:  sb = 2'b11;
            ST_EXR: begin sa = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01; aop = 2'b10; end
            ST_WBR: begin rdst = 2'b01; rw = 1; end
            ST_MA:  begin sa = 2'b01; sb = 2'b10; end
            ST_MRD: begin iord = 1; mrd = 1; end
            ST_MWB: begin m2r = 2'b01; rw = 1; end
            ST_MWR: begin iord = 1; mwr = 1; end
            ST_EXI: begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
            ST_WBI: rw = 1;
            ST_BEQ: begin sa = 2'b01; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            ST_J:   begin pcw = 1; pcs = 2'b10; end
            ST_JAL: begin pcw = 1; pcs = 2'b10; rw = 1; rdst = 2'b10; m2r = 2'b10; end
            ST_JR:  begin
                pcw = 1; pcs = 2'b11;
                if (fn == 6'h09) begin rw = 1; rdst = 2'b01; m2r = 2'b10; end
            end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, pcs,
                (op != 6'h0c), (op == 6'h0f)};
    endfunction

    function automatic bit rnd_bit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic push_stall(input int st, input int n);
        for (int k = 0; k < n; k++) plan.push_back('{st, 1'b0});
        plan.push_back('{st, 1'b1});
    endtask

    // Expands one instruction into its expected state sequence by instruction class.
    task automatic build_plan(input logic [5:0] op, input logic [5:0] fn,
                              input int if_stalls, input int mem_stalls);
        plan.delete();
        plan_legal = 1'b1;
        push_stall(ST_IF, if_stalls);
        plan.push_back('{ST_ID, rnd_bit()});
        case (op)
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) plan.push_back('{ST_JR, rnd_bit()});
                else begin
                    plan.push_back('{ST_EXR, rnd_bit()});
                    plan.push_back('{ST_WBR, rnd_bit()});
                end
            end
            6'h23: begin
                plan.push_back('{ST_MA, rnd_bit()});
                push_stall(ST_MRD, mem_stalls);
                plan.push_back('{ST_MWB, rnd_bit()});
            end
            6'h2b: begin
                plan.push_back('{ST_MA, rnd_bit()});
                push_stall(ST_MWR, mem_stalls);
            end
            6'h04: plan.push_back('{ST_BEQ, rnd_bit()});
            6'h02: plan.push_back('{ST_J, rnd_bit()});
            6'h03: plan.push_back('{ST_JAL, rnd_bit()});
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: begin
                plan.push_back('{ST_EXI, rnd_bit()});
                plan.push_back('{ST_WBI, rnd_bit()});
            end
            default: plan_legal = 1'b0;
        endcase
    endtask

    // Entered at posedge+1 with the DUT in IF; returns at posedge+1 with the DUT back in IF.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int if_stalls, input int mem_stalls, input int abort_at);
        int  last;
        bit  retire_now;
        build_plan(op, fn, if_stalls, mem_stalls);
        last   = plan.size() - 1;
        OpCode = op;
        Funct  = fn;
        for (int i = 0; i <= last; i++) begin
            mem_ready  = plan[i].mr;
            retire_now = plan_legal && (i == last);
            @(negedge clk);
            check($sformatf("ctrl op%h st%0d", op, plan[i].st), obs_ctrl,
                  exp_ctrl(plan[i].st, op, fn, plan[i].mr));
            check($sformatf("state op%h", op), state, plan[i].st);
            check($sformatf("done op%h st%0d", op, plan[i].st), instr_done, retire_now);
            check($sformatf("count op%h", op), instr_count, model_count);
            if (i == abort_at) begin
                reset     = 1'b0;
                mem_ready = 1'b1;
                #1;
                model_count = 0;
                check("abort state", state, ST_IF);
                check("abort ctrl", obs_ctrl, exp_ctrl(ST_IF, op, fn, 1'b0));
                check("abort count", instr_count, 0);
                @(posedge clk);
                @(posedge clk);
                #1;
                check("abort hold", state, ST_IF);
                reset = 1'b1;
                return;
            end
            @(posedge clk);
            if (retire_now) model_count++;
            #1;
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] legal_ops [12];
        logic [5:0] o;
        legal_ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03,
                      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0f};
        if ($urandom_range(0, 9) == 0) begin
            o = 6'($urandom_range(16, 63));
            if (o == 6'h23 || o == 6'h2b) o = 6'h3e;
            return o;
        end
        return legal_ops[$urandom_range(0, 11)];
    endfunction

    function automatic logic [5:0] pick_funct();
        logic [5:0] fns [8];
        fns = '{6'h20, 6'h22, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h2a};
        if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
        return fns[$urandom_range(0, 7)];
    endfunction

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b1;
        OpCode    = 6'h00;
        Funct     = 6'h20;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst state", state, ST_IF);
            check("rst ctrl", obs_ctrl, exp_ctrl(ST_IF, 6'h00, 6'h20, 1'b0));
            check("rst done", instr_done, 0);
            check("rst count", instr_count, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, -1);   // add
        check("cnt after add", instr_count, 1);
        run_instr(6'h23, 6'h00, 2, 1, -1);   // lw with stalls
        run_instr(6'h00, 6'h00, 0, 0, -1);   // sll
        run_instr(6'h0c, 6'h00, 0, 0, -1);   // andi
        run_instr(6'h0f, 6'h00, 1, 0, -1);   // lui
        run_instr(6'h3f, 6'h00, 0, 0, -1);   // illegal
        run_instr(6'h04, 6'h00, 0, 0, -1);   // beq
        run_instr(6'h2b, 6'h00, 0, 2, 3);    // sw, reset during the write stall
        run_instr(6'h03, 6'h00, 0, 0, -1);   // jal
        run_instr(6'h00, 6'h09, 0, 0, -1);   // jalr
        check("cnt jal jalr", instr_count, 2);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            op = pick_op();
            run_instr(op, pick_funct(), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        check("final count", instr_count, model_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences a multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, IR/A/B/ALUOut/MDR holding registers.
- Decodes the same instruction subset as the single-cycle control unit.
- Spreads each instruction over 3-5 states and stalls on a memory ready handshake.
- Sits between the instruction register (OpCode/Funct) and the datapath muxes and write enables; it also keeps a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instr_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OpCode  in  6  IR[31:26]; valid from state ID onward.
- Funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero (beq).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load IR from memory data.
- RegDst  out  2  00=rt, 01=rd, 10=$31.
- MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00=PC, 01=A, 10=shamt.
- ALUSrcB  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=decode Funct, 11=decode OpCode.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A.
- ExtOp  out  1  1=sign-extend, 0=zero-extend (0 only for andi 0x0c).
- LuOp  out  1  1 for lui (0x0f).
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instr_count  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

Behaviour:
- State encodings:
  - IF=0, ID=1, EX_R=2, WB_R=3, MEMADR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, EX_I=8, WB_I=9, BEQ=10, J=11, JAL=12, JR=13.
  - Codes 14-15 are unused and go to IF next cycle with all enables 0.
- Reset (reset=0, async):
  - state=IF, instr_count=0, instr_done=0.
  - All outputs take IF-state values with mem_ready masked: MemRead=1, every write enable 0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00, ExtOp=1, LuOp=0.
- Default output rule: any output not named for a state is 0, except ExtOp.
- ExtOp and LuOp decode OpCode combinationally in every state.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - Stay in IF while mem_ready=0; go to ID on mem_ready=1.
- ID: ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by OpCode:
  - 0x00 with Funct 0x08/0x09 -> JR; other 0x00 -> EX_R.
  - 0x23/0x2b -> MEMADR.
  - 0x04 -> BEQ; 0x02 -> J; 0x03 -> JAL.
  - 0x08, 0x09, 0x0a, 0x0b, 0x0c, 0x0f -> EX_I.
  - Any other OpCode -> IF. This is an illegal instruction: no writes, instr_done=0, counter unchanged.
- EX_R: ALUSrcA=10 when Funct is 0x00, 0x02 or 0x03 (shifts), else 01; ALUSrcB=00; ALUOp=10; next WB_R.
- WB_R: RegDst=01, MemtoReg=00, RegWrite=1; retire; next IF.
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00; next MEM_RD if OpCode=0x23, else MEM_WR.
- MEM_RD: IorD=1, MemRead=1; hold until mem_ready=1, then MEM_WB.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1; retire; next IF.
- MEM_WR: IorD=1, MemWrite=1; hold until mem_ready=1; retire in the mem_ready cycle; next IF.
- EX_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11; next WB_I.
- WB_I: RegDst=00, MemtoReg=00, RegWrite=1; retire; next IF.
- BEQ: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; retire; next IF.
- J: PCWrite=1, PCSource=10; retire; next IF.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; retire; next IF.
- JR: PCWrite=1, PCSource=11. If Funct=0x09 (jalr) also RegWrite=1, RegDst=01, MemtoReg=10. Retire; next IF.
- Retire:
  - instr_done=1 for exactly the retiring cycle, which is combinational on the state.
  - instr_count increments at the clock edge that ends that cycle.
- Zero-wait latency:
  - R-type, I-type, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j, jal, jr, jalr: 3 cycles.
  - Each mem_ready=0 cycle in IF, MEM_RD or MEM_WR adds 1 cycle.
- Memory requests: MemRead/MemWrite stay asserted and the address select stays stable throughout a stall. Never assert MemRead and MemWrite together.
- Reset asserted mid-instruction: immediate return to IF, counter cleared, no partial write completes after reset is asserted.

Test Plan:
- Reset low for 3 cycles, release, mem_ready=1 -> state=0, MemRead=1, IRWrite=1 and PCWrite=1 in the first cycle after release, instr_count=0.
- R-type add (OpCode 0x00, Funct 0x20), mem_ready=1 -> states 0,1,2,3 over 4 cycles; RegWrite=1, RegDst=01 only in WB_R; instr_count=1 after WB_R.
- lw (0x23) with mem_ready low 2 cycles in IF and 1 cycle in MEM_RD -> 8 total cycles; MemRead held, IorD=1 throughout MEM_RD; RegWrite with MemtoReg=01 in MEM_WB.
- sll (0x00, Funct 0x00) -> ALUSrcA=10 in EX_R; andi (0x0c) -> ExtOp=0 and ALUOp=11 in EX_I; lui (0x0f) -> LuOp=1.
- jal (0x03) then jalr (0x00, Funct 0x09) -> 3 cycles each; JAL: RegDst=10, MemtoReg=10, PCSource=10; JR: PCSource=11, RegDst=01, RegWrite=1. Back-to-back instr_done pulses give instr_count=2.
- Illegal OpCode 0x3f -> ID returns to IF, no enables, instr_count unchanged. Reset asserted during MEM_WR stall -> state=0 asynchronously, MemWrite=0.
